uart_fifo_rx: RTL and testbench
===============================

Name: uart_fifo_rx

Overview:
UART receiver feeding a synchronous FIFO. It is the receive-side counterpart of fifo_uart.
- Deserialises 8N1-style frames (LSB first) from the asynchronous i_rx line using a DIVISOR-cycle bit period.
- Writes each valid byte into an internal DEPTH-entry FIFO, which downstream logic drains with i_r_en.
- Sits at the board RX pin ahead of the command/loopback logic.

Parameters:
WIDTH, 8, data bits per frame and FIFO word width
DEPTH, 16, FIFO entries; power of 2, >= 4
DIVISOR, 86, clk cycles per bit; even, >= 4
LEVEL, 2, almost-full/almost-empty threshold; 1 <= LEVEL < DEPTH/2

Ports:
clk  in  1  system clock; all logic on its rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  receive enable; low holds receiver idle after any frame in progress
i_rx  in  1  asynchronous serial line, idle high
i_r_en  in  1  FIFO read request
o_r_data  out  WIDTH  read data, registered
o_full  out  1  count == DEPTH
o_afull  out  1  count >= DEPTH-LEVEL
o_empty  out  1  count == 0
o_aempty  out  1  count <= LEVEL
o_busy  out  1  receiver not in IDLE
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_overflow  out  1  one-cycle pulse: valid byte dropped because FIFO full
o_parity_err  out  1  one-cycle pulse: parity mismatch (0 without macro)

Behaviour:
Input sampling:
- i_rx passes through a 2-flop synchronizer reset to 1; all decoding uses the synced value rxs.
- Edge cycle E is the first cycle rxs==0 following rxs==1.

State machine: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE -> START at E, only if i_enable=1. Bit counter loads DIVISOR/2-1.
- START: at terminal count, sample rxs (E + DIVISOR/2).
  - rxs==1: false start, return to IDLE, no pulse.
  - rxs==0: go to DATA, counter reloads DIVISOR-1.
- DATA: sample every DIVISOR cycles, WIDTH samples shifted in LSB first.
- STOP: sampled at E + DIVISOR/2 + (WIDTH+1)*DIVISOR (+DIVISOR with parity).
  - rxs==1 and FIFO not full: write strobe that cycle, then IDLE immediately (mid-stop bit), so back-to-back frames are supported.
  - rxs==1 and full: o_overflow pulse, byte dropped, then IDLE.
  - rxs==0: o_frame_err pulse, byte dropped, go to WAIT_IDLE; leave when rxs==1 (break handling).
- i_enable falling mid-frame does not abort the frame. It only blocks the next IDLE->START.

FIFO:
- Flags and count are registered.
- A write strobe updates the count and flags the following cycle: o_empty falls 1 cycle after the stop-bit sample.
- Read with i_r_en=1 and !o_empty: o_r_data updates the next cycle and the count decrements. Read while empty is ignored, and o_r_data holds its value.
- Simultaneous read and write: both occur, count unchanged. Full is judged on the pre-cycle count, so a write while full is dropped even with a concurrent read.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Reset (any cycle, including mid-frame):
- State IDLE, synchronizer=1, pointers and count 0, o_r_data=0.
- Flags: o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_busy=0.
- All pulses 0.
- Any partial frame is discarded.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: one even-parity bit follows the data bits, adding state PARITY. On mismatch the byte is dropped, o_parity_err pulses on the stop-sample cycle, and the receiver still checks the stop bit (frame error takes precedence, one pulse only).
- Undefined: no parity bit, PARITY state absent, o_parity_err tied 0.

Test Plan:
1. Reset, enable=1, send 0xA5 at DIVISOR=86 -> o_empty falls at E+43+9*86+1, read gives o_r_data=0xA5 next cycle, o_empty=1 after.
2. Send 16 bytes 0x00..0x0F back-to-back without reads, then 0x10 -> o_afull at count 14, o_full at 16, o_overflow pulse on the 17th byte; 16 reads return 0x00..0x0F in order (pointer wrap).
3. 20-cycle low glitch on i_rx -> no START completion, o_busy returns to 0, no pulses, FIFO empty.
4. Frame 0x3C with stop bit held low for 3 bit times -> o_frame_err single pulse, nothing written, receiver waits for high, then next frame 0x55 received correctly.
5. Assert i_reset at bit 4 of a frame -> all outputs at reset values next cycle; the following clean frame 0x81 is received.
6. With UART_RX_PARITY_EN: 0x07 with parity 1 -> written; 0x07 with parity 0 -> o_parity_err pulse, FIFO unchanged.

Source files
------------

// File: rtl/uart_fifo_rx.sv
// UART receiver (start, WIDTH data bits LSB first, stop) writing valid bytes into a DEPTH-entry FIFO.
// Optional even-parity bit: define UART_RX_PARITY_EN.
module uart_fifo_rx #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int DIVISOR = 86,
    parameter int LEVEL   = 2
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_rx,
    input  logic             i_r_en,
    output logic [WIDTH-1:0] o_r_data,
    output logic             o_full,
    output logic             o_afull,
    output logic             o_empty,
    output logic             o_aempty,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overflow,
    output logic             o_parity_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DIVISOR);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0]  HALF_LOAD = BC_W'(DIVISOR / 2 - 1);
    localparam logic [BC_W-1:0]  FULL_LOAD = BC_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [1:0]       sync_reg;
    logic             rx_prev_reg;
    logic             rxs;
    logic             rx_fall;
    state_t           state_reg, state_next;
    logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             wr_en, frame_err, overflow;
`ifdef UART_RX_PARITY_EN
    logic             parity_reg, parity_next;
    logic             parity_err;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] r_data_reg;
    logic             full_reg, afull_reg, empty_reg, aempty_reg;
    logic             rd_en;

    assign rxs     = sync_reg[1];
    assign rx_fall = rx_prev_reg & ~rxs;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            sync_reg    <= {sync_reg[0], i_rx};
            rx_prev_reg <= rxs;
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        wr_en        = 1'b0;
        frame_err    = 1'b0;
        overflow     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_next  = parity_reg;
        parity_err   = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (i_enable && rx_fall) begin
                    state_next   = S_START;
                    bit_cnt_next = HALF_LOAD;
                end
            end
            S_START: begin
                if (bit_cnt_reg == '0) begin
                    // A line that is high again at mid-start-bit was only a glitch
                    if (rxs) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        bit_cnt_next = FULL_LOAD;
                        bit_idx_next = '0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_reg == '0) begin
                    shift_next   = {rxs, shift_reg[WIDTH-1:1]};
                    bit_cnt_next = FULL_LOAD;
                    if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt_reg == '0) begin
                    parity_next  = rxs;
                    bit_cnt_next = FULL_LOAD;
                    state_next   = S_STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_cnt_reg == '0) begin
                    if (!rxs) begin
                        frame_err  = 1'b1;
                        state_next = S_WAIT_IDLE;
                    end else begin
                        // Return mid-stop-bit so the next start edge is never missed
                        state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_reg, parity_reg}) parity_err = 1'b1;
                        else
`endif
                        if (full_reg) overflow = 1'b1;
                        else wr_en = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rd_en = i_r_en & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en)      count_next = count_reg + 1'b1;
        else if (rd_en && !wr_en) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            r_data_reg <= '0;
            full_reg   <= 1'b0;
            afull_reg  <= 1'b0;
            empty_reg  <= 1'b1;
            aempty_reg <= 1'b1;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                r_data_reg <= mem[rd_ptr_reg];
            end
            count_reg  <= count_next;
            full_reg   <= (count_next == CNT_W'(DEPTH));
            afull_reg  <= (count_next >= CNT_W'(DEPTH - LEVEL));
            empty_reg  <= (count_next == '0);
            aempty_reg <= (count_next <= CNT_W'(LEVEL));
        end
    end

    assign o_r_data    = r_data_reg;
    assign o_full      = full_reg;
    assign o_afull     = afull_reg;
    assign o_empty     = empty_reg;
    assign o_aempty    = aempty_reg;
    assign o_busy      = (state_reg != S_IDLE);
    assign o_frame_err = frame_err & ~i_reset;
    assign o_overflow  = overflow & ~i_reset;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err & ~i_reset;
`else
    assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_rx.sv
// Directed testbench for uart_fifo_rx: reset, single byte, fill/overflow, glitch, break, mid-frame reset, parity.
module tb_uart_fifo_rx;
    localparam int DIV = 86;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Cycles from driving the start bit to o_empty falling: 2 sync + half bit + data/parity/stop bits + 1
    localparam int EMPTY_FALL = 2 + DIV / 2 + (9 + PB) * DIV + 1;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_r_en = 1'b0;
    logic [7:0] o_r_data;
    logic       o_full, o_afull, o_empty, o_aempty, o_busy;
    logic       o_frame_err, o_overflow, o_parity_err;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

    uart_fifo_rx #(.WIDTH(8), .DEPTH(16), .DIVISOR(DIV), .LEVEL(2)) dut (
        .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_rx(i_rx), .i_r_en(i_r_en),
        .o_r_data(o_r_data), .o_full(o_full), .o_afull(o_afull), .o_empty(o_empty),
        .o_aempty(o_aempty), .o_busy(o_busy), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow), .o_parity_err(o_parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_frame_err === 1'b1) fe_cnt++;
        if (o_overflow === 1'b1) ov_cnt++;
        if (o_parity_err === 1'b1) pe_cnt++;
    end

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] fb;
        fb = {stop, par, d, 1'b0};
        for (int k = 0; k < 9; k++) send_bit(fb[k]);
`ifdef UART_RX_PARITY_EN
        send_bit(fb[9]);
`endif
        send_bit(fb[10]);
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp);
        i_r_en = 1'b1;
        @(posedge clk); #1;
        i_r_en = 1'b0;
        checks++;
        if (o_r_data !== exp) begin
            errors++;
            $display("FAIL %s: o_r_data=%h expected %h", name, o_r_data, exp);
        end
        $display("read %s data=%h", name, o_r_data);
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_rx = 1'b1; i_enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        i_reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: %b expected 1", o_empty); end
        checks++; if (o_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: %b expected 1", o_aempty); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: %b expected 0", o_full); end
        checks++; if (o_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: %b expected 0", o_afull); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b expected 0", o_busy); end
        checks++; if (o_r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: %h expected 00", o_r_data); end
        checks++;
        if ({o_frame_err, o_overflow, o_parity_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: %b expected 000", {o_frame_err, o_overflow, o_parity_err});
        end
        $display("reset done");
    endtask

    task automatic test_single;
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            begin
                repeat (EMPTY_FALL - 1) @(posedge clk); #1;
                checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL single_empty_early: %b expected 1", o_empty); end
                @(posedge clk); #1;
                checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: %b expected 0", o_empty); end
            end
        join
        read_expect("single", 8'hA5);
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: %b expected 1", o_empty); end
    endtask

    task automatic test_fill;
        int ov0;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), ^8'(i), 1'b1);
            $display("wrote byte %h", 8'(i));
            if (i == 1) begin checks++; if (o_aempty !== 1'b1) begin errors++; $display("FAIL fill_aempty2: %b expected 1", o_aempty); end end
            if (i == 2) begin checks++; if (o_aempty !== 1'b0) begin errors++; $display("FAIL fill_aempty3: %b expected 0", o_aempty); end end
            if (i == 12) begin checks++; if (o_afull !== 1'b0) begin errors++; $display("FAIL fill_afull13: %b expected 0", o_afull); end end
            if (i == 13) begin checks++; if (o_afull !== 1'b1) begin errors++; $display("FAIL fill_afull14: %b expected 1", o_afull); end end
            if (i == 14) begin checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL fill_full15: %b expected 0", o_full); end end
            if (i == 15) begin checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full16: %b expected 1", o_full); end end
        end
        ov0 = ov_cnt;
        send_frame(8'h10, ^8'h10, 1'b1);
        checks++; if (ov_cnt !== ov0 + 1) begin errors++; $display("FAIL fill_overflow: pulses=%0d expected %0d", ov_cnt - ov0, 1); end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full_after_ovf: %b expected 1", o_full); end
        for (int i = 0; i < 16; i++) read_expect($sformatf("fill_%0d", i), 8'(i));
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fill_drained: %b expected 1", o_empty); end
        read_expect("empty_hold", 8'h0F);
    endtask

    task automatic test_glitch;
        int fe0, ov0, pe0;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        i_rx = 1'b0;
        repeat (10) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: %b expected 1", o_busy); end
        repeat (10) @(posedge clk); #1;
        i_rx = 1'b1;
        repeat (60) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: %b expected 0", o_busy); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: %b expected 1", o_empty); end
        checks++;
        if ((fe_cnt != fe0) || (ov_cnt != ov0) || (pe_cnt != pe0)) begin
            errors++; $display("FAIL glitch_pulses: fe=%0d ov=%0d pe=%0d expected 0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
        end
        $display("glitch done busy=%b", o_busy);
    endtask

    task automatic test_frame_err;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        i_rx = 1'b0;
        repeat (2 * DIV) @(posedge clk); #1;
        checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL ferr_pulse: pulses=%0d expected 1", fe_cnt - fe0); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy: %b expected 1", o_busy); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ferr_empty: %b expected 1", o_empty); end
        i_rx = 1'b1;
        repeat (2 * DIV) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ferr_release: %b expected 0", o_busy); end
        send_frame(8'h55, ^8'h55, 1'b1);
        checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL ferr_single: pulses=%0d expected 1", fe_cnt - fe0); end
        read_expect("after_break", 8'h55);
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        send_frame(8'h42, ^8'h42, 1'b1);
        checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL rmid_preload: %b expected 0", o_empty); end
        d = 8'h99;
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(d[k]);
        i_rx = d[4];
        repeat (20) @(posedge clk); #1;
        i_reset = 1'b1; i_rx = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: %b expected 1", o_empty); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: %b expected 0", o_busy); end
        checks++; if (o_r_data !== 8'h00) begin errors++; $display("FAIL rmid_rdata: %h expected 00", o_r_data); end
        checks++;
        if ({o_full, o_afull, o_aempty} !== 3'b001) begin
            errors++; $display("FAIL rmid_flags: full/afull/aempty=%b expected 001", {o_full, o_afull, o_aempty});
        end
        i_reset = 1'b0;
        repeat (200) @(posedge clk); #1;
        send_frame(8'h81, ^8'h81, 1'b1);
        read_expect("after_reset", 8'h81);
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rmid_final_empty: %b expected 1", o_empty); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int pe0;
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL par_good_written: empty=%b expected 0", o_empty); end
        read_expect("parity_good", 8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        checks++; if (pe_cnt !== pe0 + 1) begin errors++; $display("FAIL par_bad_pulse: pulses=%0d expected 1", pe_cnt - pe0); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL par_bad_dropped: empty=%b expected 1", o_empty); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_fill;
        test_glitch;
        test_frame_err;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
